halt_drain_ctrl: RTL and testbench
==================================

// Module: halt_drain_ctrl
// PURPOSE
//  Sits directly downstream of the halt unit: consumes its freeze signal (halt decoded in ID,
//  PC and IF/ID frozen) and waits for older instructions in EX/MEM/WB to retire.
//  Then reports a clean halted state to the debug/host side, and runs a resume handshake
//  that squashes the halt instruction so fetch restarts. Also keeps a saturating halt counter.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles after freeze to drain EX/MEM/WB; legal range >= 1
//  CNT_W         16  width of halt_count_o
// PORTS
//  clk_i         in   1      system clock, all state on rising edge
//  rst_ni        in   1      asynchronous, active-low reset
//  freeze_i      in   1      freeze from halt unit (halt instruction held in ID)
//  pipe_empty_i  in   1      EX/MEM/WB hold no valid instruction (early drain exit)
//  resume_req_i  in   1      debug/host request to leave halt, level, sampled in HALTED only
//  halted_o      out  1      pipeline halted and drained (registered)
//  draining_o    out  1      in DRAIN state (registered)
//  resume_ack_o  out  1      1-cycle pulse, resume accepted
//  skip_halt_o   out  1      1-cycle pulse: bubble ID, unfreeze PC/IF/ID to step past halt
//  halt_count_o  out  CNT_W  number of completed halts, saturating
// BEHAVIOUR
//  Reset (rst_ni=0, async, any time incl. mid-drain/mid-resume): state=RUN, drain cnt=0,
//   halt_count_o=0, all 1-bit outputs 0. Takes effect immediately, no clock needed.
//  States: RUN, DRAIN, HALTED, RESUME. Outputs decoded from state register (Moore):
//   draining_o=(DRAIN), halted_o=(HALTED), resume_ack_o=skip_halt_o=(RESUME).
//  RUN: freeze_i=1 -> DRAIN, cnt<=0. resume_req_i ignored, not latched.
//  DRAIN: cnt increments each cycle. Exit to HALTED when cnt==DRAIN_CYCLES-1 or pipe_empty_i=1.
//   Latency freeze_i rise -> halted_o=1 is DRAIN_CYCLES+1 edges with pipe_empty_i=0.
//   Minimum is 2 edges when pipe_empty_i=1 in first DRAIN cycle.
//   freeze_i dropping during DRAIN does not abort; the drain completes.
//   resume_req_i ignored in DRAIN.
//  HALTED: held indefinitely while resume_req_i=0. resume_req_i=1 -> RESUME.
//   halt_count_o increments by 1 on the DRAIN->HALTED transition.
//   Stays at 2^CNT_W-1 once there, never wraps.
//  RESUME: exactly one cycle, then RUN unconditionally. freeze_i ignored in this cycle,
//   because the halt instruction is still in ID.
//   Next edge loads a new instruction into IF/ID. Back in RUN, freeze_i is evaluated fresh.
//   Back-to-back halts therefore re-enter DRAIN on the first RUN cycle.
//  resume_req_i still high after return to RUN has no effect.
//   A further resume needs a new HALTED episode.
//  cnt width = $clog2(DRAIN_CYCLES+1); cnt only meaningful in DRAIN, cleared on entry.
//  No combinational path from any input to any output.
// TESTING
//  1 Reset: rst_ni=0 mid-DRAIN (cnt=1), async, no clock edge -> all outputs 0 immediately.
//    After release, state RUN and halt_count_o=0.
//  2 DRAIN_CYCLES=3, pipe_empty_i=0: freeze_i rises at edge 0 -> draining_o=1 edges 1..3.
//    halted_o=1 from edge 4; halt_count_o=1.
//  3 Early exit: freeze_i=1, pipe_empty_i=1 in first DRAIN cycle -> halted_o=1 after 2 edges.
//  4 Resume: in HALTED assert resume_req_i 1 cycle -> resume_ack_o=skip_halt_o=1 for exactly 1 cycle.
//    halted_o=0, then RUN; freeze_i still 1 during RESUME -> no re-entry into DRAIN.
//  5 Ignored requests: resume_req_i=1 held during RUN and DRAIN -> no ack.
//    Ack occurs only after HALTED is reached, one cycle later.
//  6 Saturation: CNT_W=2, 5 full halt/resume loops -> halt_count_o 1,2,3,3,3.

Source files
------------

// File: rtl/halt_drain_if.sv
// Halt/drain control bundle: pipeline and host signals on one side,
// status and resume pulses on the other.
interface halt_drain_if #(
  parameter int unsigned CNT_W = 16
);
  logic             freeze;
  logic             pipe_empty;
  logic             resume_req;
  logic             halted;
  logic             draining;
  logic             resume_ack;
  logic             skip_halt;
  logic [CNT_W-1:0] halt_count;

  // Driver side: halt unit, pipeline status and debug host
  modport master (
    output freeze,
    output pipe_empty,
    output resume_req,
    input  halted,
    input  draining,
    input  resume_ack,
    input  skip_halt,
    input  halt_count
  );

  // Controller side
  modport slave (
    input  freeze,
    input  pipe_empty,
    input  resume_req,
    output halted,
    output draining,
    output resume_ack,
    output skip_halt,
    output halt_count
  );
endinterface

// File: rtl/halt_drain_ctrl.sv
// Halt drain controller: after the halt unit freezes fetch, waits for the
// older instructions in EX/MEM/WB to retire, reports a clean halted state,
// and runs a one-cycle resume that steps fetch past the halt instruction.
// Also keeps a saturating count of completed halts.
module halt_drain_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input logic         clk_i,
  input logic         rst_ni,
  halt_drain_if.slave bus
);

  localparam int unsigned      CntW     = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CountMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted,
    StResume
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State, drain counter and halt counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    case (state_q)
      StRun: begin
        if (bus.freeze) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        // freeze dropping here does not abort; older instructions still retire
        cnt_d = cnt_q + CntW'(1);
        if ((cnt_q == CntLast) || bus.pipe_empty) begin
          state_d = StHalted;
          if (count_q != CountMax) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      StHalted: begin
        if (bus.resume_req) begin
          state_d = StResume;
        end
      end
      StResume: begin
        // Halt instruction is still in ID, so freeze is ignored this cycle
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    bus.draining   = (state_q == StDrain);
    bus.halted     = (state_q == StHalted);
    bus.resume_ack = (state_q == StResume);
    bus.skip_halt  = (state_q == StResume);
    bus.halt_count = count_q;
  end

endmodule

// File: tb/tb_halt_drain_ctrl.sv
// Bench for halt_drain_ctrl: two instances sharing stimulus, one with a
// 16-bit halt counter and one with a 2-bit counter to exercise saturation.
module tb_halt_drain_ctrl;

  localparam int unsigned DC = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model: timeline of a halt episode in plain terms
  bit m_in_drain;
  bit m_halted;
  bit m_resuming;
  int m_drained;
  int m_halts;

  halt_drain_if #(.CNT_W(16)) if_a ();
  halt_drain_if #(.CNT_W(2))  if_b ();

  halt_drain_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(16)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if_a.slave)
  );

  halt_drain_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(2)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit f, input bit pe, input bit rr);
    if_a.freeze = f;  if_a.pipe_empty = pe;  if_a.resume_req = rr;
    if_b.freeze = f;  if_b.pipe_empty = pe;  if_b.resume_req = rr;
  endtask

  task automatic model_reset();
    m_in_drain = 0; m_halted = 0; m_resuming = 0; m_drained = 0; m_halts = 0;
  endtask

  // One clock edge of the specified behaviour
  task automatic model_edge(input bit f, input bit pe, input bit rr);
    if (m_resuming) begin
      m_resuming = 0;
    end else if (m_halted) begin
      if (rr) begin
        m_halted   = 0;
        m_resuming = 1;
      end
    end else if (m_in_drain) begin
      m_drained++;
      if (m_drained == DC || pe) begin
        m_in_drain = 0;
        m_halted   = 1;
        m_halts++;
      end
    end else if (f) begin
      m_in_drain = 1;
      m_drained  = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    int sat;
    sat = (m_halts > 3) ? 3 : m_halts;
    chk({ctx, ".draining"}, 32'(if_a.draining), 32'(m_in_drain));
    chk({ctx, ".halted"}, 32'(if_a.halted), 32'(m_halted));
    chk({ctx, ".resume_ack"}, 32'(if_a.resume_ack), 32'(m_resuming));
    chk({ctx, ".skip_halt"}, 32'(if_a.skip_halt), 32'(m_resuming));
    chk({ctx, ".count16"}, 32'(if_a.halt_count), 32'(m_halts));
    chk({ctx, ".count2"}, 32'(if_b.halt_count), 32'(sat));
    chk({ctx, ".b_halted"}, 32'(if_b.halted), 32'(m_halted));
  endtask

  // Apply inputs at the falling edge, clock once, check at the next falling edge
  task automatic step(input string ctx, input bit f, input bit pe, input bit rr);
    drive(f, pe, rr);
    @(posedge clk);
    model_edge(f, pe, rr);
    @(negedge clk);
    check_all(ctx);
  endtask

  // Hold freeze until halted; returns number of edges, or -1 on timeout
  task automatic halt_loop(input string ctx, input bit pe, output int edges);
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      step(ctx, 1'b1, pe, 1'b0);
      if (if_a.halted === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    int halt_k;
    int ack_k;
    int early;
    int exp_sat[5];
    checks = 0;
    errors = 0;
    exp_sat = '{1, 2, 3, 3, 3};
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    step("idle", 0, 0, 0);

    // Full drain with pipe_empty low: halted after DC+1 edges
    halt_loop("drain", 1'b0, edges);
    chk("drain_latency", 32'(edges), 32'(DC + 1));
    chk("drain_count", 32'(if_a.halt_count), 32'd1);
    step("held", 0, 0, 0);
    step("held", 0, 0, 0);

    // Resume with freeze still high: single ack, then RUN without re-drain
    step("resume", 1, 0, 1);
    chk("ack_pulse", 32'(if_a.resume_ack), 32'd1);
    step("resume_out", 1, 0, 0);
    chk("no_redrain", 32'(if_a.draining), 32'd0);
    step("run", 0, 0, 0);

    // Early exit on empty pipe
    halt_loop("early", 1'b1, edges);
    chk("early_latency", 32'(edges), 32'd2);
    step("resume2", 0, 0, 1);
    step("run2", 0, 0, 0);

    // resume_req held through RUN and DRAIN: ack only one edge after halted
    halt_k = -1; ack_k = -1; early = 0;
    step("rr_run", 0, 0, 1);
    early += int'(if_a.resume_ack);
    for (int k = 1; k <= 20; k++) begin
      step("rr_hold", 1, 0, 1);
      if (if_a.halted === 1'b1 && halt_k < 0) halt_k = k;
      if (if_a.resume_ack === 1'b1) begin
        ack_k = k;
        break;
      end
      if (halt_k < 0) early += int'(if_a.resume_ack);
    end
    chk("no_early_ack", 32'(early), 32'd0);
    chk("ack_after_halt", 32'(ack_k - halt_k), 32'd1);
    step("rr_done", 0, 0, 0);
    step("rr_done", 0, 0, 0);

    // Async reset mid-drain (drain count 1), no clock edge needed
    step("pre_rst", 1, 0, 0);
    step("pre_rst", 1, 0, 0);
    chk("mid_drain", 32'(if_a.draining), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0);

    // Saturation of the 2-bit counter over five loops
    for (int i = 0; i < 5; i++) begin
      halt_loop("sat", 1'b0, edges);
      chk("sat_count2", 32'(if_b.halt_count), 32'(exp_sat[i]));
      step("sat_resume", 0, 0, 1);
      step("sat_run", 0, 0, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 30));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
